// File: rtl/mem_arbiter.sv
// Shares one byte-serial memory engine between instruction fetch and the MEM stage.
// Latency: grant seen in IDLE -> dn_valid next cycle; dn_done -> IF_rdy/MEM_rdy next cycle.
// Backpressure: rdy_in low holds off new grants only; an in-flight transaction always completes.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              take_jmp,
  input  logic              IF_valid,
  input  logic [ADDR_W-1:0] IF_addr,
  output logic              IF_rdy,
  output logic [31:0]       IF_out,
  input  logic [1:0]        MEM_op,
  input  logic [1:0]        MEM_len,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [31:0]       MEM_data,
  output logic              MEM_rdy,
  output logic [31:0]       MEM_out,
  output logic              dn_valid,
  output logic [1:0]        dn_op,
  output logic [1:0]        dn_len,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [31:0]       dn_wdata,
  input  logic              dn_done,
  input  logic [31:0]       dn_rdata
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, COOL} state_t;

  state_t     state, state_nxt;
  logic [2:0] starve_cnt;
  logic       drop;
  logic       mem_req, if_ok, grant_if, grant_mem;

  assign mem_req = (MEM_op != OP_NOP);
  // A flush in the same cycle blocks any fetch grant.
  assign if_ok   = IF_valid && !take_jmp;

  // Next-state and grant decision; IF only beats a pending MEM request once it has starved.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (rdy_in) begin
          if (if_ok && (!mem_req || starve_cnt == LIMIT)) begin
            grant_if  = 1'b1;
            state_nxt = BUSY_IF;
          end else if (mem_req) begin
            grant_mem = 1'b1;
            state_nxt = BUSY_MEM;
          end
        end
      end
      BUSY_IF:  if (dn_done) state_nxt = COOL;
      BUSY_MEM: if (dn_done) state_nxt = COOL;
      COOL:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // Starvation counter: counts MEM grants that bypassed a waiting fetch.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_if || !IF_valid)
        starve_cnt <= '0;
      else if (grant_mem && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Engine request fields, completion pulses, result registers and the fetch drop flag.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      dn_valid <= 1'b0;
      dn_op    <= '0;
      dn_len   <= '0;
      dn_addr  <= '0;
      dn_wdata <= '0;
      IF_rdy   <= 1'b0;
      IF_out   <= '0;
      MEM_rdy  <= 1'b0;
      MEM_out  <= '0;
      drop     <= 1'b0;
    end else begin
      dn_valid <= grant_if || grant_mem;
      IF_rdy   <= 1'b0;
      MEM_rdy  <= 1'b0;
      if (grant_if) begin
        dn_op    <= OP_LOAD;
        dn_len   <= LEN_WORD;
        dn_addr  <= IF_addr;
        dn_wdata <= '0;
      end else if (grant_mem) begin
        dn_op    <= MEM_op;
        dn_len   <= MEM_len;
        dn_addr  <= MEM_addr;
        dn_wdata <= MEM_data;
      end
      if (state == BUSY_IF) begin
        // A flush on the completion cycle itself also discards the word.
        if (dn_done) begin
          if (!(drop || take_jmp)) begin
            IF_rdy <= 1'b1;
            IF_out <= dn_rdata;
          end
          drop <= 1'b0;
        end else if (take_jmp) begin
          drop <= 1'b1;
        end
      end
      if (state == BUSY_MEM && dn_done) begin
        MEM_rdy <= 1'b1;
        MEM_out <= (dn_op == OP_LOAD) ? dn_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-transaction vector table plus multi-cycle sequences.
module tb_mem_arbiter;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, SAVE = 2'b10;
  localparam logic [1:0] BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, take_jmp, IF_valid, IF_rdy, MEM_rdy;
  logic [31:0] IF_addr, IF_out, MEM_addr, MEM_data, MEM_out;
  logic [1:0]  MEM_op, MEM_len, dn_op, dn_len;
  logic        dn_valid, dn_done;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_if;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .take_jmp(take_jmp),
    .IF_valid(IF_valid), .IF_addr(IF_addr), .IF_rdy(IF_rdy), .IF_out(IF_out),
    .MEM_op(MEM_op), .MEM_len(MEM_len), .MEM_addr(MEM_addr), .MEM_data(MEM_data),
    .MEM_rdy(MEM_rdy), .MEM_out(MEM_out),
    .dn_valid(dn_valid), .dn_op(dn_op), .dn_len(dn_len), .dn_addr(dn_addr),
    .dn_wdata(dn_wdata), .dn_done(dn_done), .dn_rdata(dn_rdata)
  );

  typedef struct {
    logic        is_if;
    logic [1:0]  op;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [1:0]  e_op;
    logic [1:0]  e_len;
    logic [31:0] e_wdata;
    logic [31:0] e_out;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_in);
  endtask

  task automatic wait_issue(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (dn_valid !== 1'b1 && n < 40);
    if (dn_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: no dn_valid within %0d cycles", name, n);
    end
  endtask

  // Engine model: completes lat cycles after the issue cycle.
  task automatic serve(input int lat, input logic [31:0] rdata, input logic jmp);
    tick();
    chk("dn_valid_width", {31'b0, dn_valid}, 32'h0);
    for (int i = 1; i < lat; i++) tick();
    dn_done  = 1'b1;
    dn_rdata = rdata;
    if (jmp) take_jmp = 1'b1;
    tick();
    dn_done  = 1'b0;
    dn_rdata = '0;
    if (jmp) take_jmp = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_if_rdy"},   {31'b0, IF_rdy},   0);
    chk({p, "_mem_rdy"},  {31'b0, MEM_rdy},  0);
    chk({p, "_if_out"},   IF_out,            0);
    chk({p, "_mem_out"},  MEM_out,           0);
    chk({p, "_dn_valid"}, {31'b0, dn_valid}, 0);
    chk({p, "_dn_op"},    {30'b0, dn_op},    0);
    chk({p, "_dn_len"},   {30'b0, dn_len},   0);
    chk({p, "_dn_addr"},  dn_addr,           0);
    chk({p, "_dn_wdata"}, dn_wdata,          0);
  endtask

  initial begin
    int n;
    logic is_if;
    vec_t v;

    vt[0] = '{1'b1, NOP,  BYTE, 32'h1000, 32'h0,        32'h00C0FFEE, 8, LOAD, WORD, 32'h0,        32'h00C0FFEE};
    vt[1] = '{1'b0, LOAD, BYTE, 32'h0044, 32'h12345678, 32'hDEADBEEF, 2, LOAD, BYTE, 32'h12345678, 32'hDEADBEEF};
    vt[2] = '{1'b0, SAVE, WORD, 32'h0080, 32'hCAFEF00D, 32'h00005555, 3, SAVE, WORD, 32'hCAFEF00D, 32'h0};
    vt[3] = '{1'b1, NOP,  BYTE, 32'hFFFC, 32'hFFFFFFFF, 32'h89ABCDEF, 1, LOAD, WORD, 32'h0,        32'h89ABCDEF};
    vt[4] = '{1'b0, LOAD, HALF, 32'h0002, 32'h0,        32'h0000BEEF, 1, LOAD, HALF, 32'h0,        32'h0000BEEF};

    rst_in = 1'b0; rdy_in = 1'b1; take_jmp = 1'b0; IF_valid = 1'b0; IF_addr = '0;
    MEM_op = NOP; MEM_len = BYTE; MEM_addr = '0; MEM_data = '0; dn_done = 1'b0; dn_rdata = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_in = 1'b1;
    tick();

    // Single isolated transactions.
    for (int i = 0; i < 5; i++) begin
      v = vt[i];
      IF_valid = v.is_if; IF_addr = v.addr;
      MEM_op = v.is_if ? NOP : v.op; MEM_len = v.len; MEM_addr = v.addr; MEM_data = v.wdata;
      wait_issue($sformatf("vec%0d_issue", i), n);
      chk($sformatf("vec%0d_latency", i), n, 1);
      chk($sformatf("vec%0d_op", i), {30'b0, dn_op}, {30'b0, v.e_op});
      chk($sformatf("vec%0d_len", i), {30'b0, dn_len}, {30'b0, v.e_len});
      chk($sformatf("vec%0d_addr", i), dn_addr, v.addr);
      chk($sformatf("vec%0d_wdata", i), dn_wdata, v.e_wdata);
      serve(v.lat, v.rdata, 1'b0);
      chk($sformatf("vec%0d_if_rdy", i), {31'b0, IF_rdy}, {31'b0, v.is_if});
      chk($sformatf("vec%0d_mem_rdy", i), {31'b0, MEM_rdy}, {31'b0, !v.is_if});
      chk($sformatf("vec%0d_out", i), v.is_if ? IF_out : MEM_out, v.e_out);
      IF_valid = 1'b0; MEM_op = NOP;
      tick();
      chk($sformatf("vec%0d_pulse", i), {31'b0, IF_rdy | MEM_rdy}, 0);
      chk($sformatf("vec%0d_hold", i), v.is_if ? IF_out : MEM_out, v.e_out);
      if (v.is_if) last_if = v.e_out;
    end

    // Priority: MEM beats IF; IF decided two cycles after dn_done.
    IF_valid = 1'b1; IF_addr = 32'h3000;
    MEM_op = SAVE; MEM_len = HALF; MEM_addr = 32'h20; MEM_data = 32'hAABBCCDD;
    wait_issue("prio_issue", n);
    chk("prio_op", {30'b0, dn_op}, {30'b0, SAVE});
    chk("prio_len", {30'b0, dn_len}, {30'b0, HALF});
    chk("prio_addr", dn_addr, 32'h20);
    chk("prio_wdata", dn_wdata, 32'hAABBCCDD);
    serve(2, 32'h11111111, 1'b0);
    chk("prio_mem_rdy", {31'b0, MEM_rdy}, 1);
    chk("prio_mem_out", MEM_out, 0);
    chk("prio_if_rdy_low", {31'b0, IF_rdy}, 0);
    MEM_op = NOP;
    wait_issue("prio_if_issue", n);
    chk("prio_if_gap", n, 2);
    chk("prio_if_addr", dn_addr, 32'h3000);
    serve(1, 32'h77, 1'b0);
    chk("prio_if_rdy", {31'b0, IF_rdy}, 1);
    chk("prio_if_out", IF_out, 32'h77);
    last_if = 32'h77;
    IF_valid = 1'b0;
    tick();

    // Starvation: four MEM grants, one IF, then MEM again.
    IF_valid = 1'b1; IF_addr = 32'h4000;
    MEM_op = LOAD; MEM_len = WORD; MEM_addr = 32'h50; MEM_data = '0;
    for (int k = 0; k < 6; k++) begin
      wait_issue($sformatf("starve%0d_issue", k), n);
      chk($sformatf("starve%0d_gap", k), n, (k == 0) ? 1 : 2);
      is_if = (dn_addr == 32'h4000);
      chk($sformatf("starve%0d_is_if", k), {31'b0, is_if}, {31'b0, k == 4});
      serve(1, 32'h100 + k, 1'b0);
      if (k == 4) begin
        chk("starve_if_rdy", {31'b0, IF_rdy}, 1);
        last_if = 32'h104;
        IF_valid = 1'b0;
      end else begin
        chk($sformatf("starve%0d_mem_rdy", k), {31'b0, MEM_rdy}, 1);
      end
    end
    MEM_op = NOP;
    tick();

    // Flush during BUSY_IF.
    IF_valid = 1'b1; IF_addr = 32'h5000;
    wait_issue("flushA_issue", n);
    take_jmp = 1'b1;
    tick();
    take_jmp = 1'b0;
    serve(2, 32'h99, 1'b0);
    chk("flushA_if_rdy", {31'b0, IF_rdy}, 0);
    chk("flushA_if_out", IF_out, last_if);
    IF_valid = 1'b0;
    tick();
    chk("flushA_if_rdy_after", {31'b0, IF_rdy}, 0);

    // Flush on the dn_done cycle.
    IF_valid = 1'b1; IF_addr = 32'h6000;
    wait_issue("flushB_issue", n);
    serve(2, 32'hBB, 1'b1);
    chk("flushB_if_rdy", {31'b0, IF_rdy}, 0);
    chk("flushB_if_out", IF_out, last_if);
    IF_valid = 1'b0;
    tick();

    // Next fetch after a flush delivers normally.
    IF_valid = 1'b1; IF_addr = 32'h6004;
    wait_issue("postflush_issue", n);
    chk("postflush_latency", n, 1);
    serve(1, 32'h600D600D, 1'b0);
    chk("postflush_if_rdy", {31'b0, IF_rdy}, 1);
    chk("postflush_if_out", IF_out, 32'h600D600D);
    IF_valid = 1'b0;
    tick();

    // No fetch grant while take_jmp is high in IDLE.
    IF_valid = 1'b1; IF_addr = 32'h6100; take_jmp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("jmp_block%0d", k), {31'b0, dn_valid}, 0);
    end
    take_jmp = 1'b0;
    wait_issue("jmp_release_issue", n);
    chk("jmp_release_latency", n, 1);
    serve(1, 32'h42, 1'b0);
    chk("jmp_release_if_rdy", {31'b0, IF_rdy}, 1);
    IF_valid = 1'b0;
    tick();

    // Flush during BUSY_MEM is ignored.
    MEM_op = LOAD; MEM_len = WORD; MEM_addr = 32'h60;
    wait_issue("flushC_issue", n);
    take_jmp = 1'b1;
    serve(3, 32'hABCD0123, 1'b1);
    chk("flushC_mem_rdy", {31'b0, MEM_rdy}, 1);
    chk("flushC_mem_out", MEM_out, 32'hABCD0123);
    MEM_op = NOP;
    tick();

    // Pause: rdy_in low in IDLE blocks grants; low during BUSY has no effect.
    rdy_in = 1'b0; IF_valid = 1'b1; IF_addr = 32'h7000;
    MEM_op = SAVE; MEM_len = BYTE; MEM_addr = 32'h74; MEM_data = 32'h5A5A5A5A;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("pause%0d_dn_valid", k), {31'b0, dn_valid}, 0);
    end
    rdy_in = 1'b1;
    wait_issue("pause_issue", n);
    chk("pause_latency", n, 1);
    chk("pause_op", {30'b0, dn_op}, {30'b0, SAVE});
    rdy_in = 1'b0;
    serve(2, 32'hFFFF, 1'b0);
    chk("pause_mem_rdy", {31'b0, MEM_rdy}, 1);
    chk("pause_mem_out", MEM_out, 0);
    MEM_op = NOP; IF_valid = 1'b0; rdy_in = 1'b1;
    tick();

    // Reset mid-BUSY_MEM abandons the request.
    MEM_op = LOAD; MEM_len = HALF; MEM_addr = 32'h70; MEM_data = 32'h12345678;
    wait_issue("rst_issue", n);
    tick();
    rst_in = 1'b0; MEM_op = NOP;
    tick();
    chk_zero("midrst");
    rst_in = 1'b1; dn_done = 1'b1; dn_rdata = 32'hEEEE;
    tick();
    dn_done = 1'b0; dn_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_no_rdy%0d", k), {31'b0, MEM_rdy | IF_rdy}, 0);
      tick();
    end
    IF_valid = 1'b1; IF_addr = 32'h8000;
    wait_issue("midrst_idle_issue", n);
    chk("midrst_idle_latency", n, 1);
    serve(1, 32'h8888, 1'b0);
    chk("midrst_if_rdy", {31'b0, IF_rdy}, 1);
    chk("midrst_if_out", IF_out, 32'h8888);
    IF_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single byte-serial memory engine between instruction fetch (IF) and the MEM stage. MEM (load/store) requests win by default. A starvation counter guarantees IF progress. A branch flush (`take_jmp`) cancels or discards IF traffic without ever aborting a store. The block sits between the pipeline stages and the memory engine, which is driven through a one-request/one-completion handshake.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive MEM grants tolerated while IF waits; 1..7.
- `ADDR_W`, default 32: address width.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: when low, no new grant is issued.
- `take_jmp` in 1: branch flush, level-sampled each cycle.
- `IF_valid` in 1: fetch request, held until `IF_rdy`.
- `IF_addr` in ADDR_W: fetch address.
- `IF_rdy` out 1: one-cycle completion pulse.
- `IF_out` out 32: fetched word, valid with `IF_rdy`.
- `MEM_op` in 2: NOP=00, LOAD=01, SAVE=10; non-NOP means requesting.
- `MEM_len` in 2: BYTE=00, HALF=01, WORD=10.
- `MEM_addr` in ADDR_W, `MEM_data` in 32: store address/data.
- `MEM_rdy` out 1: one-cycle completion pulse.
- `MEM_out` out 32: load result (0 for SAVE), valid with `MEM_rdy`.
- `dn_valid` out 1: one-cycle issue pulse to the engine.
- `dn_op` out 2, `dn_len` out 2, `dn_addr` out ADDR_W, `dn_wdata` out 32: request fields, held stable from issue until `dn_done`.
- `dn_done` in 1: engine completion pulse.
- `dn_rdata` in 32: engine read data, valid with `dn_done`.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, COOL.
- **IDLE**
  - If `rdy_in`=0 or there is no request: stay in IDLE.
  - Otherwise pick a winner and register the request fields; `dn_valid`=1 next cycle.
  - Go to BUSY_IF or BUSY_MEM.
- **Winner selection**
  - MEM wins if `MEM_op`!=NOP, unless `IF_valid`=1, `take_jmp`=0 and `starve_cnt`==STARVE_LIMIT; then IF wins.
  - IF is never granted in a cycle where `take_jmp`=1.
- **IF grant:** forces `dn_op`=LOAD, `dn_len`=WORD and `dn_wdata`=0.
- **MEM grant:** passes op, len, addr and data unchanged.
- **starve_cnt (3 bit)**
  - Increments on a MEM grant while `IF_valid`=1.
  - Clears on an IF grant, or in any IDLE cycle with `IF_valid`=0.
  - Saturates at STARVE_LIMIT.
- **BUSY_IF**
  - `take_jmp`=1 in any BUSY_IF cycle, including the `dn_done` cycle, sets `drop`.
  - On `dn_done`: if `drop`=0, register `IF_out`=`dn_rdata` and pulse `IF_rdy`; if `drop`=1, suppress both.
  - Clear `drop`, then go to COOL.
- **BUSY_MEM**
  - `take_jmp` is ignored.
  - On `dn_done`: register `MEM_out` (`dn_rdata` for LOAD, 0 for SAVE), pulse `MEM_rdy`, then go to COOL.
- **COOL:** exactly one cycle with no grant, so each requester can drop or replace its request after seeing `rdy`; then go to IDLE.
- **`rdy_in`=0 outside IDLE:** has no effect, so an in-flight engine transaction always completes.

## Timing
- **Reset** (`rst_in`=0 at a clock edge):
  - State IDLE, `starve_cnt`=0, `drop`=0.
  - All outputs 0: `IF_rdy`, `MEM_rdy`, `IF_out`, `MEM_out`, `dn_valid`, `dn_op`, `dn_len`, `dn_addr`, `dn_wdata`.
  - Reset mid-transaction abandons it; no pulse follows.
- **Grant latency:** a request seen in IDLE in cycle t gives `dn_valid`=1 in cycle t+1.
- **Completion latency:** `dn_done` in cycle d gives `IF_rdy`/`MEM_rdy` in cycle d+1 (COOL); the earliest next grant decision is in cycle d+2.
- **Pulse widths:** `dn_valid`, `IF_rdy` and `MEM_rdy` are exactly one cycle; `IF_out`/`MEM_out` hold until the next pulse on the same port.
- **`dn_done` in the same cycle as `dn_valid`:** illegal; the engine needs at least one cycle.
- **Both pulses:** never asserted in the same cycle.
- **Simultaneous flush and dn_done:** resolved by the BUSY_IF rules under Operation.

## Test plan
- **Single fetch:** `IF_valid`, `IF_addr`=0x1000; engine returns 0x00C0FFEE after 8 cycles → `dn_op`=LOAD, `dn_len`=WORD, `dn_addr`=0x1000; `IF_rdy` one cycle after `dn_done` with `IF_out`=0x00C0FFEE.
- **Priority:** IF and MEM SAVE (addr 0x20, data 0xAABBCCDD, HALF) requested together → MEM issued first with `dn_wdata`=0xAABBCCDD and `dn_len`=HALF; `MEM_out`=0 at `MEM_rdy`; IF issued at `dn_done`+2.
- **Starvation:** MEM held continuously with IF waiting, STARVE_LIMIT=4 → exactly 4 MEM grants, then one IF grant, then MEM resumes.
- **Flush:**
  - `take_jmp` during BUSY_IF → `dn_done` produces no `IF_rdy`.
  - `take_jmp` on the `dn_done` cycle → no `IF_rdy`.
  - `take_jmp` during BUSY_MEM → `MEM_rdy` still pulses.
- **Pause:** `rdy_in`=0 for 5 cycles in IDLE with requests → no `dn_valid`; the grant follows 1 cycle after `rdy_in` rises.
- **Reset:** `rst_in`=0 mid-BUSY_MEM → all outputs 0, state IDLE, and no `MEM_rdy` for the abandoned request.
